// File: rtl/blast_damage_handler.sv
// -----------------------------------------------------------------------------
// blast_damage_handler
//
// Turns per-pixel player/blast collisions into at most one hit per video
// frame. Owns the player's life count, the post-hit invulnerability window
// (counted in OneSecPulse ticks), the sprite blink mask during that window,
// and the sticky game-over flag.
//
// Ports:
//   clk            in   system clock
//   resetN         in   synchronous reset, active-high
//   startOfFrame   in   one-cycle pulse per video frame (SOF)
//   OneSecPulse    in   one-cycle pulse per second
//   player_DR      in   player sprite draw request at current pixel
//   blast_DR       in   blast draw request at current pixel
//   add_life       in   one-cycle life power-up pulse
//   lives          out  current life count (saturates at 0 and MAX_LIVES)
//   player_hit     out  one-cycle pulse when a hit is committed
//   invulnerable   out  high while in the invulnerability window
//   player_visible out  sprite enable mask (blinks while invulnerable)
//   game_over      out  sticky, high once the last life is lost
// -----------------------------------------------------------------------------
module blast_damage_handler #(
    parameter int START_LIVES  = 3,
    parameter int MAX_LIVES    = 7,
    parameter int INVULN_SECS  = 3,
    parameter int BLINK_FRAMES = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       OneSecPulse,
    input  logic       player_DR,
    input  logic       blast_DR,
    input  logic       add_life,
    output logic [2:0] lives,
    output logic       player_hit,
    output logic       invulnerable,
    output logic       player_visible,
    output logic       game_over
);

    localparam int SEC_W   = $clog2(INVULN_SECS + 1);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [2:0]         START_L    = 3'(START_LIVES);
    localparam logic [2:0]         MAX_L      = 3'(MAX_LIVES);
    localparam logic [SEC_W-1:0]   SEC_LOAD   = SEC_W'(INVULN_SECS);
    localparam logic [SEC_W-1:0]   SEC_ONE    = SEC_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic               hit_pending_q, hit_pending_d;
    logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               player_hit_q, player_hit_d;
    logic               visible_q, visible_d;
    logic               invuln_q, invuln_d;
    logic               game_over_q, game_over_d;

    logic       collision;
    logic [2:0] lives_inc;
    logic [2:0] lives_after_hit;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge value of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q       <= ST_ALIVE;
            lives_q       <= START_L;
            hit_pending_q <= 1'b0;
            sec_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            player_hit_q  <= 1'b0;
            visible_q     <= 1'b1;
            invuln_q      <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            hit_pending_q <= hit_pending_d;
            sec_cnt_q     <= sec_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            player_hit_q  <= player_hit_d;
            visible_q     <= visible_d;
            invuln_q      <= invuln_d;
            game_over_q   <= game_over_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        lives_d      = lives_q;
        sec_cnt_d    = sec_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        visible_d    = visible_q;
        player_hit_d = 1'b0;

        collision = player_DR && blast_DR;
        lives_inc = (lives_q >= MAX_L) ? MAX_L : lives_q + 3'd1;

        // A hit coincident with add_life nets to zero change; the death
        // check is made on this combined value.
        if (add_life) begin
            lives_after_hit = lives_q;
        end else begin
            lives_after_hit = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
        end

        // SOF starts a fresh capture window; a collision on the SOF cycle
        // itself belongs to the new frame.
        hit_pending_d = startOfFrame ? collision : (hit_pending_q || collision);

        unique case (state_q)
            ST_ALIVE: begin
                if (startOfFrame && hit_pending_q) begin
                    player_hit_d = 1'b1;
                    if (lives_after_hit == 3'd0) begin
                        state_d   = ST_DEAD;
                        lives_d   = 3'd0;
                        visible_d = 1'b0;
                    end else begin
                        state_d     = ST_INVULN;
                        lives_d     = lives_after_hit;
                        sec_cnt_d   = SEC_LOAD;
                        blink_cnt_d = '0;
                        visible_d   = 1'b0;
                    end
                end else if (add_life) begin
                    lives_d = lives_inc;
                end
            end

            ST_INVULN: begin
                if (add_life) begin
                    lives_d = lives_inc;
                end
                if (startOfFrame) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        visible_d   = ~visible_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                // Leaving the window overrides any blink toggle on the same edge.
                if (OneSecPulse) begin
                    if (sec_cnt_q <= SEC_ONE) begin
                        sec_cnt_d   = '0;
                        blink_cnt_d = '0;
                        state_d     = ST_ALIVE;
                        visible_d   = 1'b1;
                    end else begin
                        sec_cnt_d = sec_cnt_q - 1'b1;
                    end
                end
            end

            ST_DEAD: begin
                lives_d   = 3'd0;
                visible_d = 1'b0;
            end

            default: begin
                state_d = ST_ALIVE;
            end
        endcase

        invuln_d    = (state_d == ST_INVULN);
        game_over_d = (state_d == ST_DEAD);
    end

    assign lives          = lives_q;
    assign player_hit     = player_hit_q;
    assign invulnerable   = invuln_q;
    assign player_visible = visible_q;
    assign game_over      = game_over_q;

endmodule

// File: tb/tb_blast_damage_handler.sv
// -----------------------------------------------------------------------------
// tb_blast_damage_handler
//
// Self-checking bench for blast_damage_handler: a directed vector table,
// hand-written multi-cycle corner sequences, and randomized stimulus, all
// compared against a frame/second-level behavioural model of the player.
// -----------------------------------------------------------------------------
module tb_blast_damage_handler;

    localparam int START_LIVES  = 3;
    localparam int MAX_LIVES    = 7;
    localparam int INVULN_SECS  = 3;
    localparam int BLINK_FRAMES = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       OneSecPulse;
    logic       player_DR;
    logic       blast_DR;
    logic       add_life;
    logic [2:0] lives;
    logic       player_hit;
    logic       invulnerable;
    logic       player_visible;
    logic       game_over;

    always #5 clk = ~clk;

    blast_damage_handler #(
        .START_LIVES (START_LIVES),
        .MAX_LIVES   (MAX_LIVES),
        .INVULN_SECS (INVULN_SECS),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .OneSecPulse   (OneSecPulse),
        .player_DR     (player_DR),
        .blast_DR      (blast_DR),
        .add_life      (add_life),
        .lives         (lives),
        .player_hit    (player_hit),
        .invulnerable  (invulnerable),
        .player_visible(player_visible),
        .game_over     (game_over)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // ---------------------------------------------------------------------
    // Behavioural model: the player is alive, shielded or dead; the shield
    // lasts a number of seconds and the sprite shows during the odd-numbered
    // BLINK_FRAMES-long stretches of frames since the hit.
    // ---------------------------------------------------------------------
    typedef enum int {M_ALIVE, M_SHIELDED, M_DEAD} mode_e;

    mode_e m_mode;
    int    m_lives;
    int    m_secs_left;
    int    m_frames_since_hit;
    bit    m_pending;
    bit    m_hit;

    task automatic model_reset();
        m_mode             = M_ALIVE;
        m_lives            = START_LIVES;
        m_secs_left        = 0;
        m_frames_since_hit = 0;
        m_pending          = 1'b0;
        m_hit              = 1'b0;
    endtask

    task automatic model_step(input bit rst, sof, sec, pdr, bdr, add);
        int  after;
        bit  coll;
        if (rst) begin
            model_reset();
            return;
        end
        coll  = pdr && bdr;
        m_hit = 1'b0;
        case (m_mode)
            M_ALIVE: begin
                if (sof && m_pending) begin
                    m_hit = 1'b1;
                    after = m_lives - 1 + (add ? 1 : 0);
                    if (after <= 0) begin
                        m_mode  = M_DEAD;
                        m_lives = 0;
                    end else begin
                        m_mode             = M_SHIELDED;
                        m_lives            = (after > MAX_LIVES) ? MAX_LIVES : after;
                        m_secs_left        = INVULN_SECS;
                        m_frames_since_hit = 0;
                    end
                end else if (add && m_lives < MAX_LIVES) begin
                    m_lives++;
                end
            end
            M_SHIELDED: begin
                if (add && m_lives < MAX_LIVES) m_lives++;
                if (sof) m_frames_since_hit++;
                if (sec) begin
                    m_secs_left--;
                    if (m_secs_left == 0) m_mode = M_ALIVE;
                end
            end
            default: ;
        endcase
        m_pending = sof ? coll : (m_pending || coll);
    endtask

    function automatic logic [6:0] pack(input int l, input bit h, i, v, g);
        return {3'(l), h, i, v, g};
    endfunction

    function automatic logic [6:0] model_out();
        bit vis;
        case (m_mode)
            M_ALIVE:    vis = 1'b1;
            M_SHIELDED: vis = ((m_frames_since_hit / BLINK_FRAMES) % 2) == 1;
            default:    vis = 1'b0;
        endcase
        return pack(m_lives, m_hit, m_mode == M_SHIELDED, vis, m_mode == M_DEAD);
    endfunction

    function automatic logic [6:0] dut_out();
        return {lives, player_hit, invulnerable, player_visible, game_over};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got lives=%0d hit=%b inv=%b vis=%b go=%b, want lives=%0d hit=%b inv=%b vis=%b go=%b",
                     name, $time, act[6:4], act[3], act[2], act[1], act[0],
                     exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, compare just after the edge.
    task automatic step(input bit rst, sof, sec, pdr, bdr, add);
        resetN       = rst;
        startOfFrame = sof;
        OneSecPulse  = sec;
        player_DR    = pdr;
        blast_DR     = bdr;
        add_life     = add;
        @(posedge clk);
        model_step(rst, sof, sec, pdr, bdr, add);
        #1;
        check("model", dut_out(), model_out());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Collide, commit at SOF, then sit out the whole shield window.
    task automatic hit_and_recover();
        step(0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < INVULN_SECS; k++) step(0, 0, 1, 0, 0, 0);
    endtask

    // ---------------------------------------------------------------------
    // Directed vector table
    // ---------------------------------------------------------------------
    typedef struct {
        bit         rst, sof, sec, pdr, bdr, add;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit rst, sof, sec, pdr, bdr, add, input logic [6:0] exp);
        vec_t v;
        v.rst = rst; v.sof = sof; v.sec = sec;
        v.pdr = pdr; v.bdr = bdr; v.add = add;
        v.exp = exp;
        return v;
    endfunction

    initial begin
        resetN       = 1'b1;
        startOfFrame = 1'b0;
        OneSecPulse  = 1'b0;
        player_DR    = 1'b0;
        blast_DR     = 1'b0;
        add_life     = 1'b0;
        model_reset();

        //                rst sof sec pdr bdr add   lives hit inv vis go
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, pack(3, 0, 0, 1, 0)));  // reset
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, pack(3, 0, 0, 1, 0)));  // empty frame
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, pack(3, 0, 0, 1, 0)));  // player only
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, pack(3, 0, 0, 1, 0)));  // collision captured
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, pack(3, 0, 0, 1, 0)));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, pack(2, 1, 1, 0, 0)));  // commit
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, pack(2, 0, 1, 0, 0)));  // hit is 1 cycle
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, pack(2, 0, 1, 0, 0)));  // 3 -> 2 secs
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, pack(3, 0, 1, 0, 0)));  // add while shielded
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, pack(3, 0, 1, 0, 0)));  // frame 1, hit ignored
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, pack(3, 0, 1, 0, 0)));  // frame 2
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, pack(3, 0, 1, 0, 0)));  // frame 3
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, pack(3, 0, 1, 1, 0)));  // frame 4: blink on
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, pack(3, 0, 1, 1, 0)));  // 2 -> 1 secs
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, pack(3, 0, 0, 1, 0)));  // shield ends
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, pack(3, 0, 0, 1, 0)));  // collision on SOF only
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, pack(3, 0, 0, 1, 0)));  // not yet committed
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, pack(2, 1, 1, 0, 0)));  // commit; entry sec ignored
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, pack(2, 0, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, pack(2, 0, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, pack(2, 0, 0, 1, 0)));  // third counted pulse
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, pack(3, 0, 0, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, pack(3, 0, 0, 1, 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].sof, tbl[i].sec, tbl[i].pdr, tbl[i].bdr, tbl[i].add);
            check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        // 10 quiet frames
        step(1, 0, 0, 0, 0, 0);
        for (int f = 0; f < 10; f++) begin
            idle(5);
            step(0, 1, 0, 0, 0, 0);
        end
        check("quiet_frames", dut_out(), pack(3, 0, 0, 1, 0));

        // Down to one life, then hit + add_life on the same SOF edge
        step(1, 0, 0, 0, 0, 0);
        hit_and_recover();
        hit_and_recover();
        check("one_life", dut_out(), pack(1, 0, 0, 1, 0));
        step(0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0, 1);
        check("last_life_add", dut_out(), pack(1, 1, 1, 0, 0));
        for (int k = 0; k < INVULN_SECS; k++) step(0, 0, 1, 0, 0, 0);
        check("one_life_back", dut_out(), pack(1, 0, 0, 1, 0));

        // Final hit: death is absorbing
        step(0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        check("death", dut_out(), pack(0, 1, 0, 0, 1));
        step(0, 0, 0, 1, 1, 1);
        step(0, 1, 1, 1, 1, 1);
        step(0, 1, 0, 0, 0, 0);
        check("dead_sticky", dut_out(), pack(0, 0, 0, 0, 1));

        // Saturation at MAX_LIVES
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < MAX_LIVES - START_LIVES; k++) step(0, 0, 0, 0, 0, 1);
        check("lives_max", dut_out(), pack(7, 0, 0, 1, 0));
        step(0, 0, 0, 0, 0, 1);
        check("lives_sat", dut_out(), pack(7, 0, 0, 1, 0));

        // Reset in the middle of the shield with a hit pending
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        check("reset_mid_invuln", dut_out(), pack(3, 0, 0, 1, 0));
        step(0, 1, 0, 0, 0, 0);
        check("pending_discarded", dut_out(), pack(3, 0, 0, 1, 0));

        // Randomized run against the model
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/blast_damage_handler.md
Name: blast_damage_handler

Overview:
- Consumer end of the bomb system's blast output. It takes per-pixel collisions between the player sprite and blast drawing, and turns them into at most one hit per frame.
- It owns the player's life count, a post-hit invulnerability window timed by OneSecPulse, the sprite blink mask during that window, and the game-over flag.
- It sits between the collision/draw logic and the game controller and player sprite.

Parameters:
- START_LIVES, 3, life count loaded at reset.
- MAX_LIVES, 7, saturation ceiling for add_life; must be ≤7.
- INVULN_SECS, 3, number of OneSecPulse pulses spent in invulnerability after a hit; must be ≥1.
- BLINK_FRAMES, 4, frames per toggle of player_visible while invulnerable.

Ports:
- clk  in  1  system clock; sole clock.
- resetN  in  1  reset; synchronous, active-high (asserted = 1).
- startOfFrame  in  1  one-cycle pulse per video frame.
- OneSecPulse  in  1  one-cycle pulse per second.
- player_DR  in  1  player sprite drawing request at the current pixel.
- blast_DR  in  1  blast drawing request at the current pixel.
- add_life  in  1  one-cycle life power-up pulse.
- lives  out  3  current life count.
- player_hit  out  1  one-cycle pulse when a hit is committed.
- invulnerable  out  1  high while in state INVULN.
- player_visible  out  1  sprite enable mask.
- game_over  out  1  sticky; high in state DEAD.

Behaviour:
- Reset (resetN=1 at a clk edge):
  - state=ALIVE, lives=START_LIVES, hit_pending=0, sec_cnt=0, blink_cnt=0.
  - player_hit=0, invulnerable=0, player_visible=1, game_over=0.
- All outputs are registered. Reset asserted mid-frame or mid-invulnerability discards all pending state.
- Collision capture (hit_pending):
  - Sticky flag. Set on any non-SOF cycle with player_DR&&blast_DR.
  - On an SOF cycle, hit_pending is loaded with (player_DR&&blast_DR) of that same cycle. A collision coincident with SOF therefore belongs to the new frame.
  - The commit decision at SOF uses the value hit_pending held before that edge.
- States: ALIVE, INVULN, DEAD. All decisions occur only on edges where startOfFrame=1, except the OneSecPulse countdown and add_life.
- ALIVE, SOF with hit_pending=1:
  - player_hit=1 for exactly the next cycle.
  - If lives==1: lives becomes 0, go to DEAD, game_over=1.
  - Else: lives decrements by 1, go to INVULN, sec_cnt=INVULN_SECS, blink_cnt=0, player_visible=0.
- ALIVE, SOF with hit_pending=0: no change.
- INVULN:
  - Hits are ignored; hit_pending is still cleared/reloaded at SOF, and player_hit stays 0.
  - Each OneSecPulse decrements sec_cnt. On the pulse where sec_cnt==1: sec_cnt=0, go to ALIVE, player_visible=1.
  - A OneSecPulse on the same edge as entry into INVULN is not counted.
  - Each SOF increments blink_cnt. When blink_cnt==BLINK_FRAMES-1, blink_cnt=0 and player_visible toggles.
- DEAD:
  - Absorbing until reset. lives=0, player_visible=0, invulnerable=0, game_over=1.
  - add_life and collisions are ignored.
- add_life:
  - In ALIVE/INVULN: lives=min(lives+1, MAX_LIVES) on the next edge.
  - Same edge as a committed hit: the net change is 0 (lives-1+1), state still goes to INVULN, and player_hit still pulses. The death check uses lives-1+1, so lives==1 plus a hit plus add_life gives INVULN with lives=1.
- Widths:
  - sec_cnt is $clog2(INVULN_SECS+1) bits.
  - blink_cnt is $clog2(BLINK_FRAMES) bits (minimum 1).
  - No wrap on lives: it saturates at 0 and at MAX_LIVES.
- Latency: a hit in frame N is committed at the SOF that opens frame N+1. lives and player_hit are visible one clk after that SOF edge.

Test Plan:
- Reset, then 10 frames with no collisions -> lives=3, player_visible=1, player_hit never asserted, game_over=0.
- 5-cycle collision burst mid-frame, then SOF -> one player_hit pulse exactly 1 cycle wide; lives=2; invulnerable=1; player_visible=0 and toggling every 4 frames.
- In INVULN, collisions every frame plus 3 OneSecPulse -> lives stays 2; state returns to ALIVE on the 3rd pulse; invulnerable=0, player_visible=1.
- Three hits, each spaced past invulnerability -> lives 3→2→1→0; the third hit sets game_over=1 and player_visible=0. Subsequent add_life and collisions leave lives=0.
- Boundary cases:
  - lives=1, collision in frame, add_life on the SOF edge -> lives=1, INVULN, game_over=0.
  - add_life at lives=7 -> lives=7.
  - Collision only on the SOF cycle -> no hit until the following SOF.
- Assert resetN for 1 cycle during INVULN with sec_cnt=2 -> lives=3, ALIVE, player_visible=1, pending hit discarded.
